// File: rtl/flex_counter_pkg.sv
// Shared types and default widths for the flexible counter family.
// Optional feature macro used by flex_udcounter: FLEX_UDCOUNTER_WRAP_CNT_EN.
package flex_counter_pkg;

  localparam int DEFAULT_NUM_CNT_BITS  = 4;
  localparam int DEFAULT_WRAP_CNT_BITS = 8;

  // Count direction as sampled from count_dir.
  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_t;

  // Behaviour when a count would cross the bound.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_t;

endpackage

// File: rtl/flex_udcounter_wrap_event_counter.sv
// Saturating count of bound events. Cleared by reset and by clear; sticks at
// all-ones once reached so long runs never alias back to small values.
module wrap_event_counter #(
  parameter int WRAP_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     bound_event,
  output logic [WRAP_CNT_BITS-1:0] wrap_count
);

  // Event register: clear wins, then a saturating increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wrap_count <= '0;
    end else if (clear) begin
      wrap_count <= '0;
    end else if (bound_event && (wrap_count != '1)) begin
      wrap_count <= wrap_count + WRAP_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/flex_udcounter.sv
// Up/down counter with programmable step, synchronous load, wrap or saturate
// at the bound, a registered terminal flag and a one-cycle bound-event pulse.
// Up-counting runs 1..rollover_val; clear returns to 0.
// Optional feature macro: FLEX_UDCOUNTER_WRAP_CNT_EN adds the wrap_count
// port, a saturating count of bound events.
module flex_udcounter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEFAULT_NUM_CNT_BITS
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
  ,
  parameter int WRAP_CNT_BITS = DEFAULT_WRAP_CNT_BITS
`endif
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_dir,
  input  logic                     sat_mode,
  input  logic [NUM_CNT_BITS-1:0]  step,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
  output logic [WRAP_CNT_BITS-1:0] wrap_count,
`endif
  output logic                     bound_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  cnt_dir_t                dir;
  cnt_mode_t               mode;
  logic [NUM_CNT_BITS:0]   sum;
  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_flag;
  logic                    next_event;
  logic                    count_active;

  assign dir  = cnt_dir_t'(count_dir);
  assign mode = cnt_mode_t'(sat_mode);

  // A zero bound or zero step turns an enabled cycle into a plain hold with
  // no bound event.
  assign count_active = count_enable && (rollover_val != '0) && (step != '0);

  // Next count, bound event and terminal flag from the sampled controls.
  always_comb begin
    sum        = {1'b0, count_out} + {1'b0, step};
    next_count = count_out;
    next_event = 1'b0;
    next_flag  = 1'b0;

    if (clear) begin
      next_count = '0;
    end else if (load) begin
      // Loaded value is deliberately not range-checked.
      next_count = load_val;
    end else if (count_active) begin
      if (dir == CNT_UP) begin
        if (sum <= {1'b0, rollover_val}) begin
          next_count = sum[NUM_CNT_BITS-1:0];
        end else begin
          next_event = 1'b1;
          next_count = (mode == MODE_SAT) ? rollover_val : CNT_ONE;
        end
      end else begin
        if (count_out > step) begin
          next_count = count_out - step;
        end else begin
          next_event = 1'b1;
          next_count = (mode == MODE_SAT) ? CNT_ONE : rollover_val;
        end
      end
    end

    // Terminal value depends on the direction sampled this cycle, so the
    // flag always describes the count it is registered alongside.
    if (dir == CNT_UP) begin
      next_flag = (next_count >= rollover_val) && (rollover_val != '0);
    end else begin
      next_flag = (next_count == CNT_ONE);
    end
  end

  // Output registers: count, flag and pulse update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      bound_pulse   <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
      bound_pulse   <= next_event;
    end
  end

`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
  wrap_event_counter #(
    .WRAP_CNT_BITS(WRAP_CNT_BITS)
  ) u_wrap_event_counter (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .bound_event(next_event),
    .wrap_count (wrap_count)
  );
`endif

endmodule

// File: tb/tb_flex_udcounter.sv
// Self-checking bench for flex_udcounter (NUM_CNT_BITS = 4). A behavioural
// integer model predicts every post-edge output; directed scenarios add
// hand-computed literal expectations. Honours FLEX_UDCOUNTER_WRAP_CNT_EN.
module tb_flex_udcounter;

  localparam int N = 4;
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
  localparam int WB = 8;
  localparam int W  = N + 2 + WB;
`else
  localparam int W  = N + 2;
`endif

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic         load;
  logic [N-1:0] load_val;
  logic         count_enable;
  logic         count_dir;
  logic         sat_mode;
  logic [N-1:0] step;
  logic [N-1:0] rollover_val;
  logic [N-1:0] count_out;
  logic         rollover_flag;
  logic         bound_pulse;
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
  logic [WB-1:0] wrap_count;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [W-1:0] exp_q[$];

  flex_udcounter #(
    .NUM_CNT_BITS(N)
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    ,
    .WRAP_CNT_BITS(WB)
`endif
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_dir    (count_dir),
    .sat_mode     (sat_mode),
    .step         (step),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    .wrap_count   (wrap_count),
`endif
    .bound_pulse  (bound_pulse)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_count = 0;
  int m_flag  = 0;
  int m_pulse = 0;
  int m_wrap  = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_count = 0; m_flag = 0; m_pulse = 0; m_wrap = 0;
      exp_q.delete();
    end else begin
      int c, rv, st;
      c  = m_count;
      rv = int'(rollover_val);
      st = int'(step);
      m_pulse = 0;
      if (clear) begin
        c = 0;
        m_wrap = 0;
      end else if (load) begin
        c = int'(load_val);
      end else if (count_enable && rv != 0 && st != 0) begin
        if (!count_dir) begin
          if (c + st > rv) begin
            m_pulse = 1;
            c = sat_mode ? rv : 1;
          end else begin
            c = c + st;
          end
        end else begin
          if (c <= st) begin
            m_pulse = 1;
            c = sat_mode ? 1 : rv;
          end else begin
            c = c - st;
          end
        end
      end
      m_count = c;
      m_flag  = count_dir ? int'(c == 1) : int'(rv != 0 && c >= rv);
      if (m_pulse == 1 && m_wrap < 255) m_wrap = m_wrap + 1;
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
      exp_q.push_back({WB'(m_wrap), 1'(m_pulse), 1'(m_flag), N'(m_count)});
`else
      exp_q.push_back({1'(m_pulse), 1'(m_flag), N'(m_count)});
`endif
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en && n_rst && exp_q.size() > 0) begin
      logic [W-1:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
      act_v = {wrap_count, bound_pulse, rollover_flag, count_out};
`else
      act_v = {bound_pulse, rollover_flag, count_out};
`endif
      checks = checks + 1;
      if (act_v !== exp_v) begin
        errors = errors + 1;
        $display("FAIL model_cmp t=%0t actual=%h required=%h (count %0d/%0d flag %b/%b pulse %b/%b)",
                 $time, act_v, exp_v, act_v[N-1:0], exp_v[N-1:0], act_v[N], exp_v[N],
                 act_v[N+1], exp_v[N+1]);
      end
    end
  end

  // ---------------- driver / literal check tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input int c, input int f, input int p);
    check_lit({tag, "_count"}, int'(count_out), c);
    check_lit({tag, "_flag"},  int'(rollover_flag), f);
    check_lit({tag, "_pulse"}, int'(bound_pulse), p);
  endtask

  task automatic set_ctrl(input logic en, input logic dir, input logic sat,
                          input int st, input int rv);
    count_enable = en;
    count_dir    = dir;
    sat_mode     = sat;
    step         = N'(st);
    rollover_val = N'(rv);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c1[6] = '{1, 2, 3, 4, 5, 1};
    int f1[6] = '{0, 0, 0, 0, 1, 0};
    int p1[6] = '{0, 0, 0, 0, 0, 1};
    int c2[6] = '{5, 4, 3, 2, 1, 5};
    int f2[6] = '{0, 0, 0, 0, 1, 0};
    int p2[6] = '{1, 0, 0, 0, 0, 1};
    int c3[5] = '{2, 4, 6, 7, 7};
    int f3[5] = '{0, 0, 0, 1, 1};
    int p3[5] = '{0, 0, 0, 1, 1};

    n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    set_ctrl(1'b1, 1'b0, 1'b0, 1, 5);
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0);
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    check_lit("reset_wrap", int'(wrap_count), 0);
`endif
    n_rst  = 1'b1;
    chk_en = 1'b1;

    // Up / wrap, enable held from reset.
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_out($sformatf("upwrap%0d", i), c1[i], f1[i], p1[i]);
    end
    do_clear();
    expect_out("clr1", 0, 0, 0);

    // Down / wrap from 0.
    set_ctrl(1'b1, 1'b1, 1'b0, 1, 5);
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_out($sformatf("dnwrap%0d", i), c2[i], f2[i], p2[i]);
    end
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    check_lit("dnwrap_wrapcnt", int'(wrap_count), 2);
`endif
    do_clear();

    // Up / sat, step 2, bound 7.
    set_ctrl(1'b1, 1'b0, 1'b1, 2, 7);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("upsat%0d", i), c3[i], f3[i], p3[i]);
    end
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    check_lit("upsat_wrapcnt", int'(wrap_count), 2);
`endif

    // Down / sat, step 2, bound 5, loaded to 4: 2, then clamp at 1 twice.
    set_ctrl(1'b1, 1'b1, 1'b1, 2, 5);
    load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0;
    expect_out("dnsat_load", 4, 0, 0);
    tick(); expect_out("dnsat0", 2, 0, 0);
    tick(); expect_out("dnsat1", 1, 1, 1);
    tick(); expect_out("dnsat2", 1, 1, 1);
    do_clear();

    // Load beats enable; load may exceed the bound.
    set_ctrl(1'b1, 1'b0, 1'b0, 1, 10);
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    expect_out("load12", 12, 1, 0);
    tick();
    expect_out("after_load", 1, 0, 1);

    // Clear beats load and enable at count 9.
    load = 1'b1; load_val = 4'd9;
    tick();
    expect_out("load9", 9, 0, 0);
    clear = 1'b1; load_val = 4'd3;
    tick();
    clear = 1'b0; load = 1'b0;
    expect_out("clr_prio", 0, 0, 0);
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    check_lit("clr_wrapcnt", int'(wrap_count), 0);
`endif
    set_ctrl(1'b1, 1'b0, 1'b0, 0, 10);
    tick(); expect_out("step0_a", 0, 0, 0);
    tick(); expect_out("step0_b", 0, 0, 0);

    // Direction change takes effect at the sampled edge.
    set_ctrl(1'b1, 1'b0, 1'b0, 3, 9);
    tick(); expect_out("dirchg0", 3, 0, 0);
    count_dir = 1'b1;
    tick(); expect_out("dirchg1", 9, 0, 1);
    tick(); expect_out("dirchg2", 6, 0, 0);

    // Async reset between edges at count 3.
    do_clear();
    set_ctrl(1'b1, 1'b0, 1'b0, 1, 5);
    repeat (3) tick();
    expect_out("pre_rst", 3, 0, 0);
    #2 n_rst = 1'b0;
    #1 expect_out("async_rst", 0, 0, 0);
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    check_lit("async_rst_wrap", int'(wrap_count), 0);
`endif
    rollover_val = '0;
    #1 n_rst = 1'b1;
    tick(); expect_out("rv0_a", 0, 0, 0);
    tick(); expect_out("rv0_b", 0, 0, 0);

    // Long run of back-to-back events: bound 1 pulses every cycle and
    // drives the event count into saturation.
    set_ctrl(1'b1, 1'b0, 1'b0, 1, 1);
    tick(); expect_out("rv1_first", 1, 1, 0);
    tick(); expect_out("rv1_evt", 1, 1, 1);
    repeat (270) tick();
    expect_out("rv1_long", 1, 1, 1);
`ifdef FLEX_UDCOUNTER_WRAP_CNT_EN
    check_lit("wrap_sat", int'(wrap_count), 255);
`endif

    set_ctrl(1'b0, 1'b0, 1'b0, 1, 5);
    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flex_udcounter.md
# flex_udcounter

Parametrised up/down successor to the team's flexible counter, used for FFT address, stage and butterfly index generation where a plain up-counter that wraps at a fixed value is not enough. It adds:
- programmable step and direction
- synchronous load
- wrap or saturate mode
- a one-cycle bound-event pulse

Count range and flag semantics stay compatible with the existing counter: up-counting runs 1..rollover_val, the flag is registered, and clear returns to 0.

## Interface
- NUM_CNT_BITS, 4, width of count, load, step and rollover values
- WRAP_CNT_BITS, 8, width of wrap_count (used only with FLEX_UDCOUNTER_WRAP_CNT_EN)
- clk  input  1  clock, all state on rising edge
- n_rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear to 0, highest synchronous priority
- load  input  1  synchronous load of load_val
- load_val  input  NUM_CNT_BITS  value loaded by load
- count_enable  input  1  advance by step this cycle
- count_dir  input  1  0 = up, 1 = down; sampled each cycle
- sat_mode  input  1  0 = wrap at bound, 1 = clamp at bound
- step  input  NUM_CNT_BITS  increment/decrement magnitude; 0 = hold
- rollover_val  input  NUM_CNT_BITS  upper bound; 0 is illegal
- count_out  output  NUM_CNT_BITS  registered count, reset 0
- rollover_flag  output  1  registered terminal flag, reset 0
- bound_pulse  output  1  registered one-cycle bound-event pulse, reset 0
- wrap_count  output  WRAP_CNT_BITS  bound-event count, reset 0 (macro only)

## Operation
- Priority: clear > load > count_enable > hold.
- clear: next = 0.
- load: next = load_val. The value is not range-checked; it may exceed rollover_val.
- Up count: sum = count_out + step, computed in NUM_CNT_BITS+1 bits.
  - sum <= rollover_val: next = sum.
  - Otherwise, wrap mode: next = 1. Sat mode: next = rollover_val.
- Down count:
  - count_out > step: next = count_out - step.
  - Otherwise, wrap mode: next = rollover_val. Sat mode: next = 1.
- A bound event is any enabled count that takes the "otherwise" branch. Wrap events and clamp attempts both count, and a clamp while already at the bound also counts.
- step = 0 with enable: next = count_out, no bound event.
- rollover_val = 0: count_enable is ignored (hold). clear and load still act.
- rollover_flag is computed from next and the current count_dir:
  - Up: next >= rollover_val and rollover_val != 0.
  - Down: next == 1.
- bound_pulse: registered value of the bound-event condition. It is never set by clear or load.

## Timing
- All outputs are registered.
- count_out, rollover_flag and bound_pulse change together one edge after the sampled control. There is no combinational input-to-output path.
- rollover_flag is high in exactly the cycles where count_out holds the terminal value for the direction sampled at the producing edge.
- bound_pulse lasts one cycle per event. Back-to-back events give a continuously high pulse.
- A direction, step or mode change takes effect at the same edge it is sampled. There is no pipeline flush.
- Async reset mid-operation: all outputs go to 0 immediately, without waiting for clk. The first edge after n_rst rises evaluates normally from count 0.

## Configuration
- FLEX_UDCOUNTER_WRAP_CNT_EN defined:
  - The wrap_count port and its register exist.
  - Increments on every bound event.
  - Saturates at all-ones.
  - Cleared by clear and by reset; load does not affect it.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package flex_counter_pkg holds:
  - cnt_dir_t enum (CNT_UP = 0, CNT_DOWN = 1)
  - cnt_mode_t enum (MODE_WRAP = 0, MODE_SAT = 1)
  - Default width constants
- Natural sub-module: wrap_event_counter, a saturating event counter parametrised by WRAP_CNT_BITS. It is instantiated only under the macro.
- Next-state and flag logic sit in one always_comb block; registers sit in one always_ff block.

## Test plan
All scenarios use NUM_CNT_BITS = 4.
- Up/wrap, rollover_val = 5, step = 1, enable held from reset -> count_out 1,2,3,4,5,1. rollover_flag high only while count = 5. bound_pulse high only in the cycle count returns to 1.
- Down/wrap, rollover_val = 5, step = 1, from 0 -> count_out 5,4,3,2,1,5. rollover_flag high while count = 1. bound_pulse with each 5, including the first.
- Up/sat, rollover_val = 7, step = 2 -> count_out 2,4,6,7,7. rollover_flag high from the first 7. bound_pulse high for both 7 cycles. With the macro defined, wrap_count = 2.
- Load vs enable, rollover_val = 10: load = 1, load_val = 12, enable = 1 -> count_out 12, rollover_flag 1, bound_pulse 0. Next enabled up-count -> count_out 1, bound_pulse 1.
- clear with load and enable in the same cycle at count 9 -> count_out 0, rollover_flag 0, bound_pulse 0, wrap_count 0. Then step = 0 with enable -> count holds at 0.
- n_rst pulsed low between edges at count 3 -> all outputs 0 immediately. With rollover_val = 0 afterwards, enable -> count_out stays 0 and rollover_flag stays 0.
